// File: rtl/motor_control_pkg.sv
// ============================================================================
// motor_control_pkg: register map, CTRL/STATUS bit positions, channel status
// Rev 1.0
// ============================================================================
`default_nettype none

package motor_control_pkg;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_TARGET    = 3'd1;
    localparam logic [2:0] REG_CURRENT   = 3'd2;
    localparam logic [2:0] REG_SENS_CNT  = 3'd3;
    localparam logic [2:0] REG_LAST_LAP  = 3'd4;
    localparam logic [2:0] REG_BEST_LAP  = 3'd5;
    localparam logic [2:0] REG_LAP_CNT   = 3'd6;
    localparam logic [2:0] REG_STATUS    = 3'd7;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_FCLR_BIT = 1;
    localparam int CTRL_WDOG_BIT = 2;

    localparam int STAT_FAULT_BIT = 0;
    localparam int STAT_LAPV_BIT  = 1;

    typedef struct packed {
        logic lap_valid;
        logic fault;
    } ch_status_t;

endpackage

`default_nettype wire

// File: rtl/motor_channel.sv
// ============================================================================
// motor_channel: one lane - input filtering, ramped PWM, lap timer, watchdog
// Rev 1.0
// ============================================================================
`default_nettype none

module motor_channel
    import motor_control_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int PWM_MAX    = 1000,
    parameter int RAMP_STEP  = 10,
    parameter int DEB_CYCLES = 4,
    parameter int LAP_W      = 32,
    parameter int WDOG_TICKS = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             wrap,
    input  logic [CNT_W-1:0] pwm_cnt,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [2:0]       reg_sel,
    input  logic [31:0]      wdata,
    input  logic             sensor_in,
    input  logic             round_in,
    output logic [31:0]      rd_word,
    output logic             pwm_out,
    output logic             enable_out
);

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int WD_W  = $clog2(WDOG_TICKS + 1);

    logic [1:0] w_raw, r_meta, r_sync, w_filt, r_filt_d, w_rise;

    assign w_raw  = {round_in, sensor_in};
    assign w_rise = w_filt & ~r_filt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta   <= '0;
            r_sync   <= '0;
            r_filt_d <= '0;
        end else begin
            r_meta   <= w_raw;
            r_sync   <= r_meta;
            r_filt_d <= w_filt;
        end
    end

    // Filtered level follows the synchronised input only after it has
    // disagreed for DEB_CYCLES consecutive cycles.
    for (genvar g = 0; g < 2; g++) begin : g_deb
        logic [DEB_W-1:0] r_cnt;
        logic             r_lvl;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt <= '0;
                r_lvl <= 1'b0;
            end else if (r_sync[g] == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                r_cnt <= '0;
                r_lvl <= r_sync[g];
            end else begin
                r_cnt <= r_cnt + DEB_W'(1);
            end
        end
        assign w_filt[g] = r_lvl;
    end

    logic             r_ctrl_en, r_wdog_en, r_armed;
    logic [CNT_W-1:0] r_target, r_current, w_diff, w_step, w_tgt_sat;
    logic [31:0]      r_sens_cnt, r_lap_cnt;
    logic [LAP_W-1:0] r_lap_tmr, r_last, r_best, w_lap_next;
    logic [WD_W-1:0]  r_wd;
    ch_status_t       r_stat;
    logic             w_sens_edge, w_round_edge, w_wr_ctrl, w_fclr, w_active;
    logic             w_capture, w_wd_run, w_expire, w_rd_last;

    assign w_sens_edge  = w_rise[0];
    assign w_round_edge = w_rise[1];
    assign w_wr_ctrl    = wr_en && (reg_sel == REG_CTRL);
    assign w_fclr       = w_wr_ctrl && wdata[CTRL_FCLR_BIT];
    assign w_active     = r_ctrl_en && !r_stat.fault;
    assign w_rd_last    = rd_en && (reg_sel == REG_LAST_LAP);
    assign w_tgt_sat    = (wdata > 32'(PWM_MAX)) ? CNT_W'(PWM_MAX) : wdata[CNT_W-1:0];
    assign w_diff       = (r_target > r_current) ? (r_target - r_current) : (r_current - r_target);
    assign w_step       = (w_diff > CNT_W'(RAMP_STEP)) ? CNT_W'(RAMP_STEP) : w_diff;
    // Lap length includes the tick of the capturing cycle.
    assign w_lap_next   = (tick && (r_lap_tmr != '1)) ? (r_lap_tmr + LAP_W'(1)) : r_lap_tmr;
    assign w_capture    = r_ctrl_en && r_armed && w_round_edge;
    assign w_wd_run     = w_active && r_wdog_en && tick;
    assign w_expire     = w_wd_run && !w_sens_edge && (r_wd == WD_W'(WDOG_TICKS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl_en  <= 1'b0;
            r_wdog_en  <= 1'b0;
            r_target   <= '0;
            r_current  <= '0;
            r_sens_cnt <= '0;
            pwm_out    <= 1'b0;
            enable_out <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ctrl_en <= wdata[CTRL_EN_BIT];
                r_wdog_en <= wdata[CTRL_WDOG_BIT];
            end
            if (wr_en && (reg_sel == REG_TARGET))
                r_target <= w_tgt_sat;
            if (!w_active)
                r_current <= '0;
            else if (wrap)
                r_current <= (r_target > r_current) ? (r_current + w_step) : (r_current - w_step);
            if (w_sens_edge)
                r_sens_cnt <= r_sens_cnt + 32'd1;
            pwm_out    <= w_active && (pwm_cnt < r_current);
            enable_out <= w_active;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed   <= 1'b0;
            r_lap_tmr <= '0;
            r_last    <= '0;
            r_best    <= '1;
            r_lap_cnt <= '0;
        end else begin
            if (!r_ctrl_en)
                r_armed <= 1'b0;
            else if (w_round_edge)
                r_armed <= 1'b1;
            r_lap_tmr <= (r_ctrl_en && w_round_edge) ? '0 : w_lap_next;
            if (w_capture) begin
                r_last    <= w_lap_next;
                r_best    <= (w_lap_next < r_best) ? w_lap_next : r_best;
                r_lap_cnt <= r_lap_cnt + 32'd1;
            end
        end
    end

    // Expiry takes precedence over a simultaneous fault clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wd   <= '0;
            r_stat <= '0;
        end else begin
            if (w_fclr || w_sens_edge || w_expire)
                r_wd <= '0;
            else if (w_wd_run)
                r_wd <= r_wd + WD_W'(1);
            if (w_expire)
                r_stat.fault <= 1'b1;
            else if (w_fclr)
                r_stat.fault <= 1'b0;
            if (w_capture)
                r_stat.lap_valid <= 1'b1;
            else if (w_rd_last)
                r_stat.lap_valid <= 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_CTRL:     rd_word = {29'd0, r_wdog_en, 1'b0, r_ctrl_en};
            REG_TARGET:   rd_word = 32'(r_target);
            REG_CURRENT:  rd_word = 32'(r_current);
            REG_SENS_CNT: rd_word = r_sens_cnt;
            REG_LAST_LAP: rd_word = 32'(r_last);
            REG_BEST_LAP: rd_word = 32'(r_best);
            REG_LAP_CNT:  rd_word = r_lap_cnt;
            REG_STATUS:   rd_word = {30'd0, r_stat.lap_valid, r_stat.fault};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/motor_control_mc.sv
// ============================================================================
// motor_control_mc: N-lane motor controller, Avalon-MM slave, shared PWM base
// Rev 1.0
// ============================================================================
`default_nettype none

module motor_control_mc
    import motor_control_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 10,
    parameter int PWM_MAX    = 1000,
    parameter int PRESCALE   = 50,
    parameter int RAMP_STEP  = 10,
    parameter int DEB_CYCLES = 4,
    parameter int LAP_W      = 32,
    parameter int WDOG_TICKS = 500000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(NUM_CH)+2:0]   address,
    input  logic                        read,
    input  logic                        write,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [NUM_CH-1:0]           pwm_output,
    output logic [NUM_CH-1:0]           enable_signal,
    input  logic [NUM_CH-1:0]           sensor_signal,
    input  logic [NUM_CH-1:0]           round_signal
);

    localparam int PS_W = $clog2(PRESCALE + 1);

    logic [PS_W-1:0]  r_ps;
    logic [CNT_W-1:0] r_pwm_cnt;
    logic             w_tick, w_wrap;
    logic [31:0]      w_ch, w_rdata;
    logic [31:0]      w_rd_word [NUM_CH];

    assign w_tick = (r_ps == PS_W'(PRESCALE - 1));
    assign w_wrap = w_tick && (r_pwm_cnt == CNT_W'(PWM_MAX - 1));
    assign w_ch   = 32'(address >> 3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ps      <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_ps <= w_tick ? '0 : (r_ps + PS_W'(1));
            if (w_tick)
                r_pwm_cnt <= w_wrap ? '0 : (r_pwm_cnt + CNT_W'(1));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        motor_channel #(
            .CNT_W      (CNT_W),
            .PWM_MAX    (PWM_MAX),
            .RAMP_STEP  (RAMP_STEP),
            .DEB_CYCLES (DEB_CYCLES),
            .LAP_W      (LAP_W),
            .WDOG_TICKS (WDOG_TICKS)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (w_tick),
            .wrap       (w_wrap),
            .pwm_cnt    (r_pwm_cnt),
            .wr_en      (write && (w_ch == 32'(g))),
            .rd_en      (read && (w_ch == 32'(g))),
            .reg_sel    (address[2:0]),
            .wdata      (writedata),
            .sensor_in  (sensor_signal[g]),
            .round_in   (round_signal[g]),
            .rd_word    (w_rd_word[g]),
            .pwm_out    (pwm_output[g]),
            .enable_out (enable_signal[g])
        );
    end

    // Addresses beyond the last channel read as zero.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (w_ch == 32'(i))
                w_rdata = w_rd_word[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= read ? w_rdata : '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_motor_control_mc.sv
// ============================================================================
// tb_motor_control_mc: randomized self-checking bench against a lane model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_motor_control_mc;

    localparam int PWM_MAX = 100;
    localparam int STEP    = 10;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        read = 1'b0, write = 1'b0;
    logic [31:0] writedata = '0, readdata;
    logic [1:0]  pwm_output, enable_signal;
    logic [1:0]  sensor_signal = '0, round_signal = '0;

    int          n_checks = 0, n_fail = 0;
    int unsigned cyc = 0;
    bit          ch1_seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (reset_n && (pwm_output[1] || enable_signal[1])) ch1_seen = 1'b1;

    motor_control_mc #(
        .NUM_CH(2), .CNT_W(10), .PWM_MAX(PWM_MAX), .PRESCALE(1), .RAMP_STEP(STEP),
        .DEB_CYCLES(4), .LAP_W(32), .WDOG_TICKS(1000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .pwm_output(pwm_output),
        .enable_signal(enable_signal), .sensor_signal(sensor_signal), .round_signal(round_signal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic bus_write(input int ch, input int rg, input logic [31:0] d);
        @(negedge clk);
        address = 4'(ch * 8 + rg); writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
        @(negedge clk);
        address = 4'(ch * 8 + rg); read = 1'b1;
        @(negedge clk);
        read = 1'b0; d = readdata;
    endtask

    // Reference ramp: one period moves at most STEP toward the target.
    function automatic int ramp_next(input int cur, input int tgt);
        if (tgt > cur) return (tgt - cur > STEP) ? cur + STEP : tgt;
        return (cur - tgt > STEP) ? cur - STEP : tgt;
    endfunction

    task automatic wait_high(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!pwm_output[0]) break;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm_output[0]) begin ok = 1'b1; break; end
        end
    endtask

    // Length of the next complete high run on lane 0; returns at its first low sample.
    task automatic measure_run(output int len);
        bit ok;
        wait_high(ok);
        check("pwm_rise_seen", 32'(ok), 32'd1);
        len = ok ? 1 : 0;
        if (ok)
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (!pwm_output[0]) break;
                len++;
            end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse(input bit is_round, input int width);
        if (is_round) round_signal[0] = 1'b1; else sensor_signal[0] = 1'b1;
        repeat (width) @(negedge clk);
        round_signal[0] = 1'b0; sensor_signal[0] = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          cur, len, tgt, exp_cnt, lo, hi;
        int unsigned t0;
        int          laps[$];
        int          best;
        bit          ok;

        // Reset state
        #12;
        check("rst_pwm", 32'(pwm_output), 32'd0);
        check("rst_en", 32'(enable_signal), 32'd0);
        check("rst_rdata", readdata, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        bus_read(0, 5, d); check("rst_best", d, 32'hFFFF_FFFF);
        bus_read(0, 2, d); check("rst_cur", d, 32'd0);
        bus_read(0, 3, d); check("rst_sens", d, 32'd0);
        bus_read(1, 7, d); check("rst_status1", d, 32'd0);

        // Soft-start ramp to 35
        bus_write(0, 1, 32'd35);
        bus_write(0, 0, 32'd1);
        cur = 0;
        for (int k = 0; k < 4; k++) begin
            cur = ramp_next(cur, 35);
            measure_run(len);
            check("ramp35_run", 32'(len), 32'(cur));
            bus_read(0, 2, d); check("ramp35_cur", d, 32'(cur));
        end
        measure_run(len);
        lo = 1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm_output[0]) break;
            lo++;
        end
        check("duty35_low", 32'(lo), 32'(PWM_MAX - 35));
        measure_run(len);
        check("duty35_high", 32'(len), 32'd35);

        // Random target changes, up and down
        for (int r = 0; r < 3; r++) begin
            tgt = $urandom_range(10, 85);
            bus_write(0, 1, 32'(tgt));
            bus_read(0, 1, d); check("tgt_read", d, 32'(tgt));
            while (cur != tgt) begin
                cur = ramp_next(cur, tgt);
                measure_run(len);
                check("rand_run", 32'(len), 32'(cur));
                bus_read(0, 2, d); check("rand_cur", d, 32'(cur));
            end
        end

        // Target saturation and constant-high duty
        bus_write(0, 1, 32'd500);
        bus_read(0, 1, d); check("tgt_sat", d, 32'(PWM_MAX));
        repeat (((PWM_MAX - cur) / STEP + 2) * PWM_MAX) @(negedge clk);
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pwm_output[0]) hi++;
        end
        check("full_duty", 32'(hi), 32'd200);
        bus_read(0, 2, d); check("full_cur", d, 32'(PWM_MAX));
        check("ch1_idle", 32'(ch1_seen), 32'd0);

        // Lap timing: arm, then laps of 300, 500 and a random length
        laps = '{300, 500};
        t0 = cyc;
        pulse(1'b1, 6);
        foreach (laps[i]) begin
            t0 += laps[i];
            wait_until(t0);
            pulse(1'b1, 6);
        end
        repeat (20) @(negedge clk);
        bus_read(0, 7, d); check("lap_valid_set", d, 32'd2);
        bus_read(0, 4, d); check("last_lap", d, 32'd500);
        bus_read(0, 5, d); check("best_lap", d, 32'd300);
        bus_read(0, 6, d); check("lap_cnt", d, 32'd2);
        bus_read(0, 7, d); check("lap_valid_clr", d, 32'd0);
        laps.push_back($urandom_range(150, 700));
        t0 += laps[2];
        wait_until(t0);
        pulse(1'b1, 6);
        repeat (20) @(negedge clk);
        best = 300;
        foreach (laps[i]) if (laps[i] < best) best = laps[i];
        bus_read(0, 4, d); check("last_lap_r", d, 32'(laps[2]));
        bus_read(0, 5, d); check("best_lap_r", d, 32'(best));
        bus_read(0, 6, d); check("lap_cnt_r", d, 32'(laps.size()));

        // Sensor debounce: short glitches ignored, long pulses counted
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            len = (i == 0) ? 2 : (i == 1) ? 6 :
                  (($urandom_range(0, 1) == 0) ? $urandom_range(1, 2) : $urandom_range(6, 9));
            if (len >= 6) exp_cnt++;
            pulse(1'b0, len);
            repeat (15) @(negedge clk);
        end
        bus_read(0, 3, d); check("sens_cnt", d, 32'(exp_cnt));

        // Watchdog trip after 1000 silent ticks
        t0 = cyc;
        bus_write(0, 0, 32'd5);
        wait_until(t0 + 985);
        bus_read(0, 7, d); check("wdog_early", 32'(d[0]), 32'd0);
        wait_until(t0 + 1020);
        bus_read(0, 7, d); check("wdog_fault", 32'(d[0]), 32'd1);
        check("wdog_en_out", 32'(enable_signal[0]), 32'd0);
        check("wdog_pwm_out", 32'(pwm_output[0]), 32'd0);
        bus_read(0, 2, d); check("wdog_cur", d, 32'd0);

        // Fault clear restarts the ramp from zero
        bus_write(0, 0, 32'd3);
        bus_read(0, 7, d); check("fclr_status", 32'(d[0]), 32'd0);
        bus_read(0, 0, d); check("fclr_ctrl", d, 32'd1);
        cur = 0;
        for (int k = 0; k < 2; k++) begin
            cur = ramp_next(cur, PWM_MAX);
            measure_run(len);
            check("restart_run", 32'(len), 32'(cur));
        end

        // Asynchronous reset in the middle of a high run
        wait_high(ok);
        check("pre_rst_rise", 32'(ok), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_pwm", 32'(pwm_output), 32'd0);
        check("async_en", 32'(enable_signal), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_read(0, 5, d); check("post_rst_best", d, 32'hFFFF_FFFF);
        bus_read(0, 2, d); check("post_rst_cur", d, 32'd0);
        bus_read(0, 6, d); check("post_rst_lapcnt", d, 32'd0);
        bus_read(0, 1, d); check("post_rst_tgt", d, 32'd0);
        @(negedge clk);
        check("rd_idle", readdata, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
